// File: rtl/pipe_fft_pkg.sv
// Shared helpers for the pipelined FFT datapath.
//   clog2     : ceiling log2 used to size pointers from a depth.
//   clamp_dly : limits a requested delay to 1..maxDly.
//   wrap_sub  : (a - b) mod modulus for pointers of any depth.
package pipe_fft_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int clamp_dly(input int len, input int maxDly);
        if (len < 1) return 1;
        if (len > maxDly) return maxDly;
        return len;
    endfunction

    // Operands are already in 0..modulus-1, so one correction is enough.
    function automatic int wrap_sub(input int a, input int b, input int modulus);
        int r = a - b;
        if (r < 0) r += modulus;
        return r;
    endfunction

endpackage

// File: rtl/pipe_fft_dly_prog_if.sv
// Stream and control bundle of the programmable delay line.
//   clkEn            : pipeline enable
//   dlyLoad, dlyLen  : delay programming strobe and value
//   din, dinVal      : input sample and its valid flag
//   dout, doutVal    : delayed sample and its valid flag
//   dlyCur           : active (clamped) delay
// master = the stage feeding the delay line, slave = the delay line.
interface pipe_fft_dly_prog_if #(
    parameter int WIDTH = 66,
    parameter int AW    = 3
);
    logic             clkEn;
    logic             dlyLoad;
    logic [AW:0]      dlyLen;
    logic [WIDTH-1:0] din;
    logic             dinVal;
    logic [WIDTH-1:0] dout;
    logic             doutVal;
    logic [AW:0]      dlyCur;

    modport master (
        output clkEn, dlyLoad, dlyLen, din, dinVal,
        input  dout, doutVal, dlyCur
    );

    modport slave (
        input  clkEn, dlyLoad, dlyLen, din, dinVal,
        output dout, doutVal, dlyCur
    );
endinterface

// File: rtl/pipe_fft_dpram.sv
// Single-clock simple dual-port RAM with registered read, shaped so it
// maps onto micro RAM columns.
//   clk, nGrst  : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr   : read port; rdata updates on the edge when re=1
module pipe_fft_dpram #(
    parameter int W     = 67,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          nGrst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it stays a RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!nGrst)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/pipe_fft_dly_prog.sv
// Runtime-programmable delay line built on a self-addressed circular buffer.
//   clk, nGrst : clock, synchronous active-low reset
//   bus        : slave side of pipe_fft_dly_prog_if (enable, programming,
//                input/output samples with valids, active delay)
// A delay of 1 uses a bypass register so the RAM never reads the entry
// being written in the same cycle.
module pipe_fft_dly_prog
    import pipe_fft_pkg::*;
#(
    parameter int WIDTH    = 66,
    parameter int DEPTH    = 8,
    parameter int DLY_INIT = DEPTH,
    parameter int AW       = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nGrst,
    pipe_fft_dly_prog_if.slave   bus
);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   DLY_RST  = (AW+1)'(clamp_dly(DLY_INIT, DEPTH));
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [AW:0]      dReg, dEff;
    logic [AW:0]      fill, fillEff, fillInc;
    logic [AW-1:0]    wptr, wptrNext, raddr;
    logic             isByp;
    logic             bypSel, bypVal, fillOk;
    logic [WIDTH-1:0] bypData;
    logic [WIDTH:0]   ramQ;

    // A load takes effect in its own cycle: that cycle's sample is the first
    // one under the new delay, and it restarts the fill count.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dEff    = dReg;
        fillEff = fill;
        if (bus.dlyLoad) begin
            dEff    = (AW+1)'(clamp_dly(int'(bus.dlyLen), DEPTH));
            fillEff = '0;
        end
        isByp    = (dEff == ONE);
        raddr    = AW'(wrap_sub(int'(wptr), int'(dEff) - 1, DEPTH));
        wptrNext = (wptr == PTR_LAST) ? '0 : wptr + AW'(1);
        fillInc  = (fillEff < FILL_MAX) ? fillEff + ONE : fillEff;
    end

    pipe_fft_dpram #(.W(WIDTH + 1), .DEPTH(DEPTH), .AW(AW)) uRam (
        .clk   (clk),
        .nGrst (nGrst),
        .we    (bus.clkEn & nGrst),
        .waddr (wptr),
        .wdata ({bus.dinVal, bus.din}),
        .re    (bus.clkEn & ~isByp),
        .raddr (raddr),
        .rdata (ramQ)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!nGrst) begin
            dReg    <= DLY_RST;
            wptr    <= '0;
            fill    <= '0;
            bypSel  <= 1'b0;
            bypVal  <= 1'b0;
            bypData <= '0;
            fillOk  <= 1'b0;
        end else begin
            dReg <= dEff;
            if (bus.clkEn) begin
                wptr    <= wptrNext;
                fill    <= fillInc;
                bypSel  <= isByp;
                bypVal  <= bus.dinVal;
                bypData <= bus.din;
                // Entries older than the current fill are stale and never valid.
                fillOk  <= (fillEff >= dEff - ONE);
            end else begin
                fill <= fillEff;
            end
        end
    end

    assign bus.dout    = bypSel ? bypData : ramQ[WIDTH-1:0];
    assign bus.doutVal = bypSel ? bypVal  : (ramQ[WIDTH] & fillOk);
    assign bus.dlyCur  = dReg;
endmodule
